mdu_iter: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the single-cycle ALU in the EX stage and takes the multi-cycle work off the critical path: signed/unsigned multiply and divide, plus direct HI/LO writes. It uses a start/busy/done handshake and a flush input so that the pipeline can stall on it and cancel it.

---
 rtl/mdu_iter.sv | 165 ++++++++++++++++
 tb/tb_mdu_iter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with architectural HI/LO registers.
// Signed and unsigned multiply use shift-add, one multiplier bit per cycle.
// Signed and unsigned divide use restoring division, one quotient bit per cycle.
// MTHI/MTLO write HI/LO directly in one cycle and never raise busy.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    request, sampled only while busy=0
//   op       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
//   a, b     operands (a is also the MTHI/MTLO source)
//   flush    cancels the in-flight operation; takes priority over start
//   busy     a MULT/DIV is in progress
//   done     one-cycle pulse: HI/LO were updated at the preceding edge
//   div_zero qualified by done: the completed op was a divide by zero
//   hi, lo   architectural HI/LO registers
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO complete here
// RUN   | one shift-add or restoring-divide step per cycle, WIDTH cycles
// FIX   | sign correction and HI/LO write-back
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  // acc_hi: product upper half / partial remainder
  // acc_lo: multiplier being consumed / dividend being shifted out, quotient shifted in
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic             is_div;
  logic             neg_p;
  logic             neg_r;
  logic             b_zero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? (~a + ONE_W) : a;
    b_mag = b_neg ? (~b + ONE_W) : b;

    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    // The extra top bit is the borrow: set when the shifted remainder is below the divisor.
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    div_ok    = ~div_diff[WIDTH+1];

    prod     = {acc_hi, acc_lo};
    prod_fix = neg_p ? (~prod + ONE_2W) : prod;
    quo_fix  = neg_p ? (~acc_lo + ONE_W) : acc_lo;
    // With a zero divisor the remainder ends up holding |a|, so restoring its sign yields a.
    rem_fix  = neg_r ? (~acc_hi + ONE_W) : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (!op[2]) begin
                is_div <= op[1];
                neg_p  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (b == '0);
                acc_hi <= '0;
                acc_lo <= op[1] ? a_mag : b_mag;
                opnd   <= op[1] ? b_mag : a_mag;
                cnt    <= CNT_W'(WIDTH);
                state  <= S_RUN;
                busy   <= 1'b1;
              end else if (!op[1]) begin
                if (op[0]) lo <= a;
                else       hi <= a;
                done <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (is_div) begin
              acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt - ONE_C;
            if (cnt == ONE_C) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              lo <= b_zero ? {WIDTH{1'b1}} : quo_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            div_zero <= is_div & b_zero;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32) against an
// arithmetic reference model; directed corner cases plus random operations.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl, output bit dz);
    logic [63:0] p;
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    p  = '0;
    rh = '0;
    rl = '0;
    case (o)
      3'd0: begin p = sx * sy; {rh, rl} = p; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; {rh, rl} = p; end
      default: begin
        if (y == 0) begin
          rl = 32'hFFFF_FFFF;
          rh = x;
          dz = 1'b1;
        end else if (o == 3'd2) begin
          q  = sx / sy;
          r  = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit hold);
    logic [31:0] rh, rl;
    bit dz;
    int cyc;
    int extra;
    ref_op(o, x, y, rh, rl, dz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'd34);
    check("busy_at_done", {63'b0, busy}, 64'd0);
    check("hi", {32'b0, hi}, {32'b0, rh});
    check("lo", {32'b0, lo}, {32'b0, rl});
    check("div_zero", {63'b0, div_zero}, {63'b0, dz});
    exp_hi = rh;
    exp_lo = rl;
    if (hold) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check("single_op_held_start", 64'(extra), 64'd0);
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int cyc;
    int seen;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {29'b0, busy, done, div_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    do_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("div_neg7_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
    do_op(3'd3, 32'd100, 32'd0, 1'b0);
    do_op(3'd3, 32'd100, 32'd7, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(3'd2, 32'hFFFF_FF9C, 32'd0, 1'b0);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_done", {62'b0, done, busy}, 64'd2);
    check("mthi_hi", {32'b0, hi}, 64'h1234_5678);
    exp_hi = 32'h1234_5678;
    op = 3'b101; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_done", {62'b0, done, busy}, 64'd2);
    check("mtlo_hilo", {hi, lo}, {exp_hi, 32'h9ABC_DEF0});
    exp_lo = 32'h9ABC_DEF0;

    // reserved opcode
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'hDEAD_BEEF; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("reserved_idle", {62'b0, done, busy}, 64'd0);
    check("reserved_hilo", {hi, lo}, {exp_hi, exp_lo});

    // flush in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hilo", {hi, lo}, {exp_hi, exp_lo});

    // flush and start together
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_drop", {62'b0, done, busy}, 64'd0);

    // flush suppresses an MTHI at the same edge
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'b100; a = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_mthi", {31'b0, done, hi}, {32'b0, exp_hi});

    // random operations against the model
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: begin rx = 32'($urandom_range(0, 255)); ry = 32'($urandom_range(1, 15)); end
        default: ;
      endcase
      do_op(ro, rx, ry, 1'b0);
    end

    // reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd12345; b = 32'd678;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_outs", {29'b0, busy, done, div_zero}, 64'd0);
    check("midrun_rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("midrun_rst_no_done", 64'(cyc), 64'd0);
    do_op(3'd0, 32'd12345, 32'hFFFF_FD5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
